microsequencer: RTL and testbench
=================================

MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high: ports clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-002 The block SHALL have port n (input, 3): the N2-N0 next-address select field of the current control word.
REQ-003 The block SHALL have port inv (input, 1): the INV field; it inverts the selected condition.
REQ-004 The block SHALL have port mi (input, 1): the MI field; it saves the return address.
REQ-005 The block SHALL have port s (input, 3): the S2-S0 condition-select field.
REQ-006 The block SHALL have port cr (input, 8): the CR7-CR0 field, giving the microcode target address.
REQ-007 The block SHALL have port enc_addr (input, 8): the first microstate of the current instruction, supplied by the instruction encoder.
REQ-008 The block SHALL have ports moc, cond_ok, z, n_flag, c, v and lsm_done (inputs, 1 each), with these meanings:
- moc: memory operation complete.
- cond_ok: the ARM condition passes.
- z, n_flag, c, v: the status flags.
- lsm_done: the load/store-multiple list is exhausted.
REQ-009 The block SHALL have port state (output, 8): the registered current microstate, which drives the 8-bit address input of the microcode ROM.
REQ-010 The block SHALL have port ret_addr (output, 8): the registered return-address register, exposed for debug.

Function
REQ-011 The condition selected by s SHALL be:
- 0: moc
- 1: cond_ok
- 2: z
- 3: n_flag
- 4: c
- 5: v
- 6: lsm_done
- 7: constant 1
The effective condition is t = selected XOR inv.
REQ-012 The incrementer SHALL compute inc = state + 1, modulo 256 (255 wraps to 0).
REQ-013 On each rising clk edge without reset, state SHALL load the address selected by n:
- 000: enc_addr
- 001: 0 (fetch)
- 010: cr
- 011: inc
- 100: t ? cr : inc
- 101: t ? enc_addr : inc
- 110: t ? inc : state (hold/wait)
- 111: ret_addr (return)
REQ-014 The next state SHALL be a function of the control fields produced from the current state, so each state update takes exactly one cycle and there are no bubbles.
REQ-015 With n=110, state SHALL hold indefinitely while t=0, and SHALL advance to inc on the first edge at which t=1.
REQ-016 When mi=1 and the edge loads a value other than state, ret_addr SHALL load inc (the return address) on that edge; otherwise ret_addr SHALL hold.
REQ-017 When n=111 and mi=1 on the same edge, state SHALL load the old ret_addr, and ret_addr SHALL load inc.
REQ-018 Condition inputs SHALL be sampled only at the clock edge; their values between edges SHALL have no effect.
REQ-019 Undefined ROM addresses SHALL impose no special handling: the block follows whatever the fields present.

Reset
REQ-020 When reset=1 at a rising edge, the block SHALL set state=0 and ret_addr=0, overriding all other inputs, including a wait in progress.
REQ-021 On the first edge after reset deasserts, state SHALL update normally from the fields of microstate 0.

Structure
REQ-022 A shared package SHALL hold the following localparams:
- the N codes: N_ENC, N_FETCH, N_JUMP, N_INC, N_CJUMP, N_CENC, N_WAIT, N_RET
- the S codes: S_MOC through S_TRUE
- the address width, 8
REQ-023 The condition selection and inversion SHALL be implemented as one sub-module, microseq_cond_sel, with inputs s, inv and the seven conditions, and output t.
REQ-024 The address mux, the incrementer and the two registers SHALL reside in microsequencer.
REQ-025 A competent implementation SHALL require no more than 400 lines of RTL.

Verification
REQ-026 Reset sequence: assert reset with n=010 and cr=8'd44 -> after the edge, state=0 and ret_addr=0.
REQ-027 Decode: state=8'd3, n=000, enc_addr=8'd25 -> next state=25.
REQ-028 Memory wait: n=110, s=0, inv=0, with moc low for 3 edges and then high -> state holds for 3 cycles, then becomes state+1.
REQ-029 Inverted branch: n=100, s=2, inv=1, z=0, cr=8'd10, state=8'd30 -> next state=10. The same stimulus with z=1 -> next state=31.
REQ-030 Call and return: state=8'd20, n=010, cr=8'd40, mi=1 -> state=40 and ret_addr=21. A later n=111 -> state=21.
REQ-031 Wrap: state=8'd255, n=011 -> next state=0. A reset asserted during an n=110 wait -> state=0 on the next edge.

Source files
------------

// File: rtl/microsequencer_pkg.sv
// Shared encodings for the microsequencer: next-address select (N) codes,
// condition select (S) codes and the microstate address width.
package microsequencer_pkg;
    localparam int ADDR_W = 8;

    localparam logic [2:0] N_ENC   = 3'b000;
    localparam logic [2:0] N_FETCH = 3'b001;
    localparam logic [2:0] N_JUMP  = 3'b010;
    localparam logic [2:0] N_INC   = 3'b011;
    localparam logic [2:0] N_CJUMP = 3'b100;
    localparam logic [2:0] N_CENC  = 3'b101;
    localparam logic [2:0] N_WAIT  = 3'b110;
    localparam logic [2:0] N_RET   = 3'b111;

    localparam logic [2:0] S_MOC    = 3'd0;
    localparam logic [2:0] S_COND   = 3'd1;
    localparam logic [2:0] S_Z      = 3'd2;
    localparam logic [2:0] S_N      = 3'd3;
    localparam logic [2:0] S_C      = 3'd4;
    localparam logic [2:0] S_V      = 3'd5;
    localparam logic [2:0] S_LSM    = 3'd6;
    localparam logic [2:0] S_TRUE   = 3'd7;
endpackage

// File: rtl/microsequencer_cond_sel.sv
// Selects one of the seven status conditions (or constant true) and applies
// the INV field to produce the effective branch condition t.
module microseq_cond_sel
    import microsequencer_pkg::*;
(
    input  logic [2:0] s,
    input  logic       inv,
    input  logic       moc,
    input  logic       cond_ok,
    input  logic       z,
    input  logic       n_flag,
    input  logic       c,
    input  logic       v,
    input  logic       lsm_done,
    output logic       t
);
    logic sel;

    always_comb begin
        sel = 1'b1;
        case (s)
            S_MOC:   sel = moc;
            S_COND:  sel = cond_ok;
            S_Z:     sel = z;
            S_N:     sel = n_flag;
            S_C:     sel = c;
            S_V:     sel = v;
            S_LSM:   sel = lsm_done;
            default: sel = 1'b1;
        endcase
    end

    assign t = sel ^ inv;
endmodule

// File: rtl/microsequencer.sv
// Microcode sequencer: picks the next microstate from the N field every cycle
// and keeps a single-level return-address register for call/return.
module microsequencer
    import microsequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        n,
    input  logic              inv,
    input  logic              mi,
    input  logic [2:0]        s,
    input  logic [ADDR_W-1:0] cr,
    input  logic [ADDR_W-1:0] enc_addr,
    input  logic              moc,
    input  logic              cond_ok,
    input  logic              z,
    input  logic              n_flag,
    input  logic              c,
    input  logic              v,
    input  logic              lsm_done,
    output logic [ADDR_W-1:0] state,
    output logic [ADDR_W-1:0] ret_addr
);
    logic              t;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] next_state;

    microseq_cond_sel u_cond_sel (
        .s        (s),
        .inv      (inv),
        .moc      (moc),
        .cond_ok  (cond_ok),
        .z        (z),
        .n_flag   (n_flag),
        .c        (c),
        .v        (v),
        .lsm_done (lsm_done),
        .t        (t)
    );

    assign inc = state + 1'b1;

    always_comb begin
        next_state = inc;
        case (n)
            N_ENC:   next_state = enc_addr;
            N_FETCH: next_state = '0;
            N_JUMP:  next_state = cr;
            N_INC:   next_state = inc;
            N_CJUMP: next_state = t ? cr : inc;
            N_CENC:  next_state = t ? enc_addr : inc;
            N_WAIT:  next_state = t ? inc : state;
            N_RET:   next_state = ret_addr;
            default: next_state = inc;
        endcase
    end

    // A call only records a return address when the sequencer actually moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= '0;
            ret_addr <= '0;
        end else begin
            state <= next_state;
            if (mi && (next_state != state))
                ret_addr <= inc;
        end
    end
endmodule

// File: tb/tb_microsequencer.sv
// Randomized and directed checks of the microsequencer against a behavioural
// next-address model held in the bench.
module tb_microsequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] n = '0;
    logic       inv = 1'b0;
    logic       mi = 1'b0;
    logic [2:0] s = '0;
    logic [7:0] cr = '0;
    logic [7:0] enc_addr = '0;
    logic       moc = 1'b0, cond_ok = 1'b0, z = 1'b0, n_flag = 1'b0;
    logic       c = 1'b0, v = 1'b0, lsm_done = 1'b0;
    logic [7:0] state, ret_addr;

    int vectors = 0;
    int miscompares = 0;
    int m_state = 0;
    int m_ret = 0;

    microsequencer dut (
        .clk(clk), .reset(reset), .n(n), .inv(inv), .mi(mi), .s(s), .cr(cr),
        .enc_addr(enc_addr), .moc(moc), .cond_ok(cond_ok), .z(z), .n_flag(n_flag),
        .c(c), .v(v), .lsm_done(lsm_done), .state(state), .ret_addr(ret_addr)
    );

    always #5 clk = ~clk;

    // Apply one control word, advance the model by one edge, then clock the DUT.
    task automatic tick(input int rst_i, input int n_i, input int s_i, input int inv_i,
                        input int mi_i, input int cr_i, input int enc_i);
        bit conds [8];
        bit t;
        int inc, nxt;
        reset = rst_i[0]; n = n_i[2:0]; s = s_i[2:0]; inv = inv_i[0]; mi = mi_i[0];
        cr = cr_i[7:0]; enc_addr = enc_i[7:0];
        conds = '{moc, cond_ok, z, n_flag, c, v, lsm_done, 1'b1};
        t = conds[s_i] ^ inv_i[0];
        inc = (m_state + 1) % 256;
        case (n_i)
            0: nxt = enc_i;
            1: nxt = 0;
            2: nxt = cr_i;
            3: nxt = inc;
            4: nxt = t ? cr_i : inc;
            5: nxt = t ? enc_i : inc;
            6: nxt = t ? inc : m_state;
            default: nxt = m_ret;
        endcase
        if (rst_i != 0) begin
            m_state = 0;
            m_ret = 0;
        end else begin
            if (mi_i != 0 && nxt != m_state) m_ret = inc;
            m_state = nxt;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(0, 2, 7, 0, 1, 99, 0);
        tick(1, 2, 7, 0, 0, 44, 0);
        vectors++;
        if (state !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        vectors++;
        if (ret_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_ret: got %0d expected 0", ret_addr);
        end
        tick(0, 3, 7, 0, 0, 0, 0);
        vectors++;
        if (state !== 8'd1) begin
            miscompares++;
            $display("FAIL post_reset_inc: got %0d expected 1", state);
        end
    endtask

    task automatic test_decode();
        tick(0, 2, 7, 0, 0, 3, 0);
        tick(0, 0, 7, 0, 0, 0, 25);
        vectors++;
        if (state !== 8'd25) begin
            miscompares++;
            $display("FAIL decode: got %0d expected 25", state);
        end
    endtask

    task automatic test_wait();
        tick(0, 2, 7, 0, 0, 60, 0);
        moc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 6, 0, 0, 0, 0, 0);
            vectors++;
            if (state !== 8'd60) begin
                miscompares++;
                $display("FAIL wait_hold%0d: got %0d expected 60", i, state);
            end
        end
        moc = 1'b1;
        tick(0, 6, 0, 0, 0, 0, 0);
        vectors++;
        if (state !== 8'd61) begin
            miscompares++;
            $display("FAIL wait_release: got %0d expected 61", state);
        end
        moc = 1'b0;
    endtask

    task automatic test_branch();
        tick(0, 2, 7, 0, 0, 30, 0);
        z = 1'b0;
        tick(0, 4, 2, 1, 0, 10, 0);
        vectors++;
        if (state !== 8'd10) begin
            miscompares++;
            $display("FAIL inv_branch_taken: got %0d expected 10", state);
        end
        tick(0, 2, 7, 0, 0, 30, 0);
        z = 1'b1;
        tick(0, 4, 2, 1, 0, 10, 0);
        vectors++;
        if (state !== 8'd31) begin
            miscompares++;
            $display("FAIL inv_branch_not_taken: got %0d expected 31", state);
        end
        z = 1'b0;
    endtask

    task automatic test_call_ret();
        tick(0, 2, 7, 0, 0, 20, 0);
        tick(0, 2, 7, 0, 1, 40, 0);
        vectors++;
        if (state !== 8'd40 || ret_addr !== 8'd21) begin
            miscompares++;
            $display("FAIL call: got state=%0d ret=%0d expected state=40 ret=21", state, ret_addr);
        end
        tick(0, 3, 7, 0, 0, 0, 0);
        tick(0, 7, 7, 0, 0, 0, 0);
        vectors++;
        if (state !== 8'd21) begin
            miscompares++;
            $display("FAIL return: got %0d expected 21", state);
        end
        // Return while saving: jumps to the old return address, saves inc.
        tick(0, 2, 7, 0, 1, 70, 0);
        tick(0, 7, 7, 0, 1, 0, 0);
        vectors++;
        if (state !== 8'd22 || ret_addr !== 8'd71) begin
            miscompares++;
            $display("FAIL ret_with_mi: got state=%0d ret=%0d expected state=22 ret=71", state, ret_addr);
        end
    endtask

    task automatic test_wrap();
        tick(0, 2, 7, 0, 0, 255, 0);
        tick(0, 3, 7, 0, 0, 0, 0);
        vectors++;
        if (state !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap: got %0d expected 0", state);
        end
        tick(0, 2, 7, 0, 0, 90, 0);
        moc = 1'b0;
        tick(0, 6, 0, 0, 0, 0, 0);
        tick(1, 6, 0, 0, 0, 0, 0);
        vectors++;
        if (state !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_in_wait: got %0d expected 0", state);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            {moc, cond_ok, z, n_flag, c, v, lsm_done} = 7'($urandom);
            tick(($urandom_range(0, 39) == 0) ? 1 : 0, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 255), $urandom_range(0, 255));
            vectors++;
            if (state !== 8'(m_state) || ret_addr !== 8'(m_ret)) begin
                miscompares++;
                $display("FAIL random%0d: got state=%0d ret=%0d expected state=%0d ret=%0d",
                         i, state, ret_addr, m_state, m_ret);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_wait();
        test_branch();
        test_call_ret();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
